mesa_ro_pingpong_ctrl: RTL and testbench
========================================

// Module: mesa_ro_pingpong_ctrl
// PURPOSE
// - Ping-pong scheduler in front of two mesa_ro_buffer instances (A=0, B=1) on the Mesa ro -> USB3 FT600 TX path.
// - Steers each Mesa read-reply byte burst into a free buffer and seals it with push_done.
// - Drains sealed buffers to the FT600 write FIFO in arrival order, gating pop clock-enable on FIFO space.
// - Lets one reply be captured while the previous one is streamed out.
// PARAMETERS
// - depth_len   512  bytes per buffer; must match the mesa_ro_buffer instances
// - depth_bits  9    log2(depth_len)
// - start_tmo   8    pop_ck_en strobes allowed between pop_en and first dout_rdy before the drain aborts
// PORTS
// - clk            in   1   system clock
// - reset          in   1   asynchronous, active-high
// - ro_din_en      in   1   Mesa ro byte strobe
// - ro_din_d       in   8   Mesa ro byte
// - ro_done        in   1   end-of-reply pulse; may coincide with the last ro_din_en
// - usb_ck_en      in   1   FT600 byte-slot strobe
// - usb_txe        in   1   1 = FT600 TX FIFO can accept a byte
// - usb_wr         out  1   byte valid to FT600
// - usb_d          out  8   byte to FT600
// - buf_din_en     out  2   per-buffer push strobe
// - buf_din_d      out  8   shared push data
// - buf_push_done  out  2   per-buffer seal pulse
// - buf_pop_ck_en  out  2   per-buffer pop clock-enable
// - buf_pop_en     out  2   per-buffer pop start level
// - buf_pop_rdy    in   2   buffer sealed and ready to pop
// - buf_dout_rdy   in   2   buffer output byte valid
// - buf_dout_d     in   16  {B[7:0],A[7:0]} buffer output bytes
// - ro_busy        out  1   both buffers occupied; upstream must hold off
// - err_ovf        out  1   sticky: byte dropped (both full or count reached depth_len)
// - err_tmo        out  1   sticky: drain start timeout
// BEHAVIOUR
// - Reset: all outputs 0; both buffer states EMPTY; wr_sel=0, rd_sel=0; byte counts 0.
// - Per-buffer state: EMPTY -> FILLING (first byte) -> SEALED (ro_done) -> DRAINING (pop started) -> EMPTY.
// - Fill: buf_din_en[wr_sel]=ro_din_en and buf_din_d=ro_din_d, both registered with 1-cycle latency.
//   - Bytes arriving while buffer[wr_sel] is SEALED or DRAINING are dropped and set err_ovf.
//   - Per-buffer count saturates at depth_len; a byte arriving at that count is dropped and sets err_ovf.
// - Seal: on ro_done with a FILLING buffer, pulse buf_push_done[wr_sel] for 1 cycle and toggle wr_sel.
//   - ro_done with zero bytes captured is ignored; wr_sel does not toggle.
//   - ro_din_en coincident with ro_done: the byte is stored first, then the buffer is sealed.
// - ro_busy=1 when buffer[wr_sel] is SEALED or DRAINING.
// - Drain FSM states: IDLE, START, RUN, FLUSH.
//   - buf_pop_ck_en[rd_sel] = usb_ck_en & usb_txe while not IDLE; the other bit stays 0.
//   - IDLE -> START when buf_pop_rdy[rd_sel]=1 and buffer[rd_sel] is SEALED.
//     - Drive buf_pop_en[rd_sel]=1, which the buffer samples as a rising edge on a gated strobe.
//     - Buffer state becomes DRAINING.
//   - START -> RUN on the first buf_dout_rdy[rd_sel]=1.
//   - START -> IDLE after start_tmo gated strobes with no buf_dout_rdy: set err_tmo, free the buffer (EMPTY), toggle rd_sel.
//   - RUN: on each gated strobe with buf_dout_rdy[rd_sel]=1, register usb_wr=1 and usb_d=dout byte. Otherwise usb_wr=0.
//   - RUN -> FLUSH on buf_dout_rdy[rd_sel] falling.
//   - FLUSH: drop buf_pop_en; on the next gated strobe, set buffer EMPTY, toggle rd_sel, return to IDLE.
// - usb_txe=0 freezes the drain: no pop clock-enable reaches the buffer and usb_wr=0, so no byte is lost or repeated.
// - Drain order equals seal order, because rd_sel and wr_sel toggle in the same sequence.
// - Fill and drain of opposite buffers run concurrently. Fill and drain never target the same buffer.
// - Reset mid-operation aborts everything; the buffers share the same reset.
// STRUCTURE
// - Package mesa_ro_pkg: buffer-state enum (EMPTY, FILLING, SEALED, DRAINING), drain-FSM enum, default depth constants.
// - One sub-module, mesa_ro_drain_fsm: drain FSM plus timeout counter.
//   - Fill/seal logic and per-buffer state stay in the top module.
// - The two mesa_ro_buffer instances sit outside this block (instantiated by the parent).
// TESTING
// - Single 4-byte reply 11,22,33,44 then ro_done, usb_txe=1 -> usb_d 11,22,33,44 on 4 usb_wr strobes; buffer A returns to EMPTY.
// - Two back-to-back replies A: 01..10 and B: 81..83 -> B is captured while A drains; output order is 01..10 then 81..83; ro_busy never asserts.
// - usb_txe deasserted for 20 cycles mid-drain -> usb_wr=0 throughout the stall; output sequence is complete with no duplicate or missing byte.
// - Third reply arrives while A is draining and B is sealed -> ro_busy=1; its bytes are dropped; err_ovf=1; A and B drain intact.
// - ro_done with no bytes, and ro_done coincident with the last byte -> the first is ignored (wr_sel unchanged); the second stores and seals the last byte.
// - Reset asserted mid-drain -> usb_wr=0 and all states EMPTY; the next reply drains correctly from buffer A.

Source files
------------

// File: rtl/mesa_ro_pkg.sv
// Shared types and default sizing for the Mesa ro -> FT600 ping-pong path.
package mesa_ro_pkg;

  localparam int DEPTH_LEN  = 512;
  localparam int DEPTH_BITS = 9;
  localparam int START_TMO  = 8;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_SEALED,
    BUF_DRAINING
  } buf_state_t;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_START,
    DR_RUN,
    DR_FLUSH
  } drain_state_t;

  function automatic logic buf_occupied(buf_state_t s);
    return (s == BUF_SEALED) || (s == BUF_DRAINING);
  endfunction

endpackage

// File: rtl/mesa_ro_drain_fsm.sv
// Drains sealed buffers to the FT600 in rd_sel order; usb_wr/usb_d registered 1 cycle after a gated strobe.
// Backpressure: usb_txe=0 suppresses the pop clock-enable, so the buffer and usb_wr both freeze.
module mesa_ro_drain_fsm
  import mesa_ro_pkg::*;
#(
  parameter int start_tmo = START_TMO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        usb_ck_en_i,
  input  logic        usb_txe_i,
  input  logic [1:0]  pop_rdy_i,
  input  logic [1:0]  dout_rdy_i,
  input  logic [15:0] dout_d_i,
  input  logic [1:0]  sealed_i,
  output logic        rd_sel_o,
  output logic        start_o,
  output logic        free_o,
  output logic [1:0]  pop_ck_en_o,
  output logic [1:0]  pop_en_o,
  output logic        usb_wr_o,
  output logic [7:0]  usb_d_o,
  output logic        err_tmo_o
);

  localparam int TW = $clog2(start_tmo + 1);

  drain_state_t  state_q;
  logic          rd_sel_q;
  logic          pop_en_q;
  logic          usb_wr_q;
  logic [7:0]    usb_d_q;
  logic          err_tmo_q;
  logic [TW-1:0] tmo_q;

  logic       gated;
  logic       rdy;
  logic [7:0] dout_byte;
  logic       abort;

  assign gated     = usb_ck_en_i & usb_txe_i;
  assign rdy       = dout_rdy_i[rd_sel_q];
  assign dout_byte = rd_sel_q ? dout_d_i[15:8] : dout_d_i[7:0];
  assign start_o   = (state_q == DR_IDLE) && pop_rdy_i[rd_sel_q] && sealed_i[rd_sel_q];
  assign abort     = (state_q == DR_START) && gated && !rdy && (tmo_q == TW'(start_tmo - 1));
  assign free_o    = abort || ((state_q == DR_FLUSH) && gated);

  assign pop_ck_en_o = ((state_q != DR_IDLE) && gated) ? (2'b01 << rd_sel_q) : 2'b00;
  assign pop_en_o    = pop_en_q ? (2'b01 << rd_sel_q) : 2'b00;
  assign rd_sel_o    = rd_sel_q;
  assign usb_wr_o    = usb_wr_q;
  assign usb_d_o     = usb_d_q;
  assign err_tmo_o   = err_tmo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DR_IDLE;
      rd_sel_q  <= 1'b0;
      pop_en_q  <= 1'b0;
      usb_wr_q  <= 1'b0;
      usb_d_q   <= 8'h00;
      err_tmo_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      usb_wr_q <= 1'b0;
      case (state_q)
        DR_IDLE: begin
          if (start_o) begin
            state_q  <= DR_START;
            pop_en_q <= 1'b1;
            tmo_q    <= '0;
          end
        end
        DR_START: begin
          // The first byte may be consumed on the very strobe that reveals it.
          if (rdy) begin
            state_q <= DR_RUN;
            if (gated) begin
              usb_wr_q <= 1'b1;
              usb_d_q  <= dout_byte;
            end
          end else if (abort) begin
            state_q   <= DR_IDLE;
            pop_en_q  <= 1'b0;
            err_tmo_q <= 1'b1;
            rd_sel_q  <= ~rd_sel_q;
          end else if (gated) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DR_RUN: begin
          if (!rdy) begin
            state_q  <= DR_FLUSH;
            pop_en_q <= 1'b0;
          end else if (gated) begin
            usb_wr_q <= 1'b1;
            usb_d_q  <= dout_byte;
          end
        end
        DR_FLUSH: begin
          if (gated) begin
            state_q  <= DR_IDLE;
            rd_sel_q <= ~rd_sel_q;
          end
        end
        default: state_q <= DR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mesa_ro_pingpong_ctrl.sv
// Ping-pong capture of Mesa ro replies into two buffers and in-order drain to the FT600; push path 1 cycle, seal 2 cycles.
// Backpressure: ro_busy when the write-side buffer is still occupied; FT600 stalls via usb_txe freeze the drain.
module mesa_ro_pingpong_ctrl
  import mesa_ro_pkg::*;
#(
  parameter int depth_len  = DEPTH_LEN,
  parameter int depth_bits = DEPTH_BITS,
  parameter int start_tmo  = START_TMO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ro_din_en,
  input  logic [7:0]  ro_din_d,
  input  logic        ro_done,
  input  logic        usb_ck_en,
  input  logic        usb_txe,
  output logic        usb_wr,
  output logic [7:0]  usb_d,
  output logic [1:0]  buf_din_en,
  output logic [7:0]  buf_din_d,
  output logic [1:0]  buf_push_done,
  output logic [1:0]  buf_pop_ck_en,
  output logic [1:0]  buf_pop_en,
  input  logic [1:0]  buf_pop_rdy,
  input  logic [1:0]  buf_dout_rdy,
  input  logic [15:0] buf_dout_d,
  output logic        ro_busy,
  output logic        err_ovf,
  output logic        err_tmo
);

  localparam int CW = depth_bits + 1;

  buf_state_t  bstate_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic        wr_sel_q;
  logic [1:0]  din_en_q;
  logic [7:0]  din_d_q;
  logic [1:0]  seal_q;
  logic [1:0]  push_done_q;
  logic        err_ovf_q;

  buf_state_t wr_state;
  logic       wr_open;
  logic       accept;
  logic       seal;
  logic [1:0] sealed_vec;
  logic       rd_sel;
  logic       drain_start;
  logic       drain_free;

  assign wr_state   = bstate_q[wr_sel_q];
  assign wr_open    = (wr_state == BUF_EMPTY) || (wr_state == BUF_FILLING);
  assign accept     = ro_din_en && wr_open && (cnt_q[wr_sel_q] < CW'(depth_len));
  assign seal       = ro_done && ((wr_state == BUF_FILLING) || accept);
  assign sealed_vec = {bstate_q[1] == BUF_SEALED, bstate_q[0] == BUF_SEALED};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bstate_q[0] <= BUF_EMPTY;
      bstate_q[1] <= BUF_EMPTY;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      wr_sel_q    <= 1'b0;
      din_en_q    <= 2'b00;
      din_d_q     <= 8'h00;
      seal_q      <= 2'b00;
      push_done_q <= 2'b00;
      err_ovf_q   <= 1'b0;
    end else begin
      din_en_q    <= 2'b00;
      seal_q      <= 2'b00;
      // Seal trails the push stage so a coincident last byte lands before push_done.
      push_done_q <= seal_q;
      if (accept) begin
        din_en_q[wr_sel_q]  <= 1'b1;
        din_d_q             <= ro_din_d;
        cnt_q[wr_sel_q]     <= cnt_q[wr_sel_q] + 1'b1;
        bstate_q[wr_sel_q]  <= BUF_FILLING;
      end
      if (ro_din_en && !accept) begin
        err_ovf_q <= 1'b1;
      end
      if (seal) begin
        seal_q[wr_sel_q]   <= 1'b1;
        bstate_q[wr_sel_q] <= BUF_SEALED;
        wr_sel_q           <= ~wr_sel_q;
      end
      // Drain only touches SEALED/DRAINING buffers, never the one being filled.
      if (drain_start) begin
        bstate_q[rd_sel] <= BUF_DRAINING;
      end
      if (drain_free) begin
        bstate_q[rd_sel] <= BUF_EMPTY;
        cnt_q[rd_sel]    <= '0;
      end
    end
  end

  mesa_ro_drain_fsm #(
    .start_tmo (start_tmo)
  ) u_drain (
    .clk         (clk),
    .reset       (reset),
    .usb_ck_en_i (usb_ck_en),
    .usb_txe_i   (usb_txe),
    .pop_rdy_i   (buf_pop_rdy),
    .dout_rdy_i  (buf_dout_rdy),
    .dout_d_i    (buf_dout_d),
    .sealed_i    (sealed_vec),
    .rd_sel_o    (rd_sel),
    .start_o     (drain_start),
    .free_o      (drain_free),
    .pop_ck_en_o (buf_pop_ck_en),
    .pop_en_o    (buf_pop_en),
    .usb_wr_o    (usb_wr),
    .usb_d_o     (usb_d),
    .err_tmo_o   (err_tmo)
  );

  assign buf_din_en    = din_en_q;
  assign buf_din_d     = din_d_q;
  assign buf_push_done = push_done_q;
  assign ro_busy       = buf_occupied(wr_state);
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_mesa_ro_pingpong_ctrl.sv
// Directed bench for mesa_ro_pingpong_ctrl with a behavioural model of the two external ro buffers.
module tb_mesa_ro_pingpong_ctrl;

  logic        clk;
  logic        reset;
  logic        ro_din_en;
  logic [7:0]  ro_din_d;
  logic        ro_done;
  logic        usb_ck_en;
  logic        usb_txe;
  logic        usb_wr;
  logic [7:0]  usb_d;
  logic [1:0]  buf_din_en;
  logic [7:0]  buf_din_d;
  logic [1:0]  buf_push_done;
  logic [1:0]  buf_pop_ck_en;
  logic [1:0]  buf_pop_en;
  logic [1:0]  buf_pop_rdy;
  logic [1:0]  buf_dout_rdy;
  logic [15:0] buf_dout_d;
  logic        ro_busy;
  logic        err_ovf;
  logic        err_tmo;

  mesa_ro_pingpong_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ro_din_en     (ro_din_en),
    .ro_din_d      (ro_din_d),
    .ro_done       (ro_done),
    .usb_ck_en     (usb_ck_en),
    .usb_txe       (usb_txe),
    .usb_wr        (usb_wr),
    .usb_d         (usb_d),
    .buf_din_en    (buf_din_en),
    .buf_din_d     (buf_din_d),
    .buf_push_done (buf_push_done),
    .buf_pop_ck_en (buf_pop_ck_en),
    .buf_pop_en    (buf_pop_en),
    .buf_pop_rdy   (buf_pop_rdy),
    .buf_dout_rdy  (buf_dout_rdy),
    .buf_dout_d    (buf_dout_d),
    .ro_busy       (ro_busy),
    .err_ovf       (err_ovf),
    .err_tmo       (err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: show-ahead output, advances on pop_ck_en while dout_rdy; starts on a sampled pop_en rise.
  logic [7:0] mem [2][512];
  int         wcnt [2];
  int         ridx [2];
  bit         sealed_m [2];
  bit         reading [2];
  bit         pe_prev [2];
  bit         mute [2];

  assign buf_dout_rdy[0] = reading[0] && !mute[0] && (ridx[0] < wcnt[0]);
  assign buf_dout_rdy[1] = reading[1] && !mute[1] && (ridx[1] < wcnt[1]);
  assign buf_pop_rdy[0]  = sealed_m[0] && !reading[0];
  assign buf_pop_rdy[1]  = sealed_m[1] && !reading[1];
  assign buf_dout_d      = {mem[1][ridx[1][8:0]], mem[0][ridx[0][8:0]]};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        wcnt[b] <= 0; ridx[b] <= 0; sealed_m[b] <= 1'b0; reading[b] <= 1'b0; pe_prev[b] <= 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (buf_din_en[b]) begin
          mem[b][wcnt[b][8:0]] <= buf_din_d;
          wcnt[b] <= wcnt[b] + 1;
        end
        if (buf_push_done[b]) sealed_m[b] <= 1'b1;
        if (buf_pop_ck_en[b]) begin
          pe_prev[b] <= buf_pop_en[b];
          if (buf_pop_en[b] && !pe_prev[b] && sealed_m[b] && !reading[b]) begin
            reading[b] <= 1'b1;
            ridx[b]    <= 0;
          end else if (buf_dout_rdy[b]) begin
            ridx[b] <= ridx[b] + 1;
            if (ridx[b] + 1 == wcnt[b]) begin
              reading[b] <= 1'b0; sealed_m[b] <= 1'b0; wcnt[b] <= 0;
            end
          end
        end
      end
    end
  end

  logic [7:0] out_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] tx_q  [$];
  int din_cnt [2];
  int pd_cnt  [2];
  int pck_cnt [2];
  bit busy_seen;
  bit overlap;

  always @(negedge clk) begin
    if (usb_wr) out_q.push_back(usb_d);
    if (|buf_din_en && |buf_pop_ck_en) overlap = 1'b1;
    for (int b = 0; b < 2; b++) begin
      if (buf_din_en[b])    din_cnt[b]++;
      if (buf_push_done[b]) pd_cnt[b]++;
      if (buf_pop_ck_en[b]) pck_cnt[b]++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit coinc);
    for (int i = 0; i < tx_q.size(); i++) begin
      ro_din_en = 1'b1;
      ro_din_d  = tx_q[i];
      ro_done   = coinc && (i == tx_q.size() - 1);
      busy_seen = busy_seen | ro_busy;
      tick();
    end
    ro_din_en = 1'b0;
    ro_done   = 1'b0;
    if (!coinc) begin
      ro_done = 1'b1;
      tick();
      ro_done = 1'b0;
    end
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, out_q.size(), n);
  endtask

  task automatic check_seq(input string tag);
    logic [31:0] v;
    for (int i = 0; i < exp_q.size(); i++) begin
      v = 'x;
      if (i < out_q.size()) v = 32'(out_q[i]);
      chk(tag, v, 32'(exp_q[i]));
    end
  endtask

  int d0, p0, c1, k;
  int stall_wr;

  initial begin
    reset = 1'b1; ro_din_en = 1'b0; ro_din_d = 8'h00; ro_done = 1'b0;
    usb_ck_en = 1'b1; usb_txe = 1'b1; mute[0] = 1'b0; mute[1] = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_usb", {usb_wr, usb_d}, 9'h000);
    chk("rst_bufctl", {buf_din_en, buf_push_done, buf_pop_ck_en, buf_pop_en}, 8'h00);
    chk("rst_din_d", buf_din_d, 8'h00);
    chk("rst_flags", {ro_busy, err_ovf, err_tmo}, 3'b000);

    // T1: single reply
    out_q.delete();
    tx_q  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(1'b0);
    wait_out(4, 200, "t1_count");
    check_seq("t1_data");
    repeat (6) tick();
    chk("t1_din_cnt_a", din_cnt[0], 4);
    chk("t1_pd_cnt_a", pd_cnt[0], 1);
    chk("t1_idle", {buf_pop_en, buf_pop_ck_en, buf_pop_rdy}, 6'b000000);

    // T2: back-to-back replies, second captured while the first drains
    out_q.delete(); busy_seen = 1'b0; overlap = 1'b0;
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10};
    send(1'b0);
    repeat (8) tick();
    tx_q = '{8'h81, 8'h82, 8'h83};
    send(1'b0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10,
              8'h81, 8'h82, 8'h83};
    wait_out(19, 300, "t2_count");
    check_seq("t2_data");
    chk("t2_busy", busy_seen, 1'b0);
    chk("t2_overlap", overlap, 1'b1);
    repeat (6) tick();

    // T3: FT600 stall mid-drain
    out_q.delete();
    tx_q  = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8, 8'ha9};
    exp_q = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8, 8'ha9};
    send(1'b0);
    k = 0;
    while (out_q.size() < 3 && k < 100) begin tick(); k++; end
    usb_txe = 1'b0;
    stall_wr = 0;
    repeat (20) begin
      tick();
      if (usb_wr) stall_wr++;
    end
    chk("t3_stall_wr", stall_wr, 0);
    usb_txe = 1'b1;
    wait_out(10, 200, "t3_count");
    check_seq("t3_data");
    repeat (6) tick();

    // T4: third reply while one buffer drains and the other is sealed
    out_q.delete();
    usb_txe = 1'b0;
    tx_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    send(1'b0);
    repeat (6) tick();
    tx_q = '{8'h61, 8'h62, 8'h63};
    send(1'b0);
    repeat (4) tick();
    chk("t4_busy", ro_busy, 1'b1);
    chk("t4_ovf_before", err_ovf, 1'b0);
    d0 = din_cnt[0] + din_cnt[1];
    p0 = pd_cnt[0] + pd_cnt[1];
    tx_q = '{8'h71, 8'h72};
    send(1'b0);
    repeat (3) tick();
    chk("t4_ovf_after", err_ovf, 1'b1);
    chk("t4_dropped", din_cnt[0] + din_cnt[1] - d0, 0);
    chk("t4_no_seal", pd_cnt[0] + pd_cnt[1] - p0, 0);
    usb_txe = 1'b1;
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h61, 8'h62, 8'h63};
    wait_out(8, 300, "t4_count");
    repeat (10) tick();
    chk("t4_no_extra", out_q.size(), 8);
    check_seq("t4_data");

    // T5: empty ro_done ignored; ro_done coincident with last byte
    out_q.delete();
    p0 = pd_cnt[0] + pd_cnt[1];
    ro_done = 1'b1; tick(); ro_done = 1'b0;
    repeat (4) tick();
    chk("t5_empty_done", pd_cnt[0] + pd_cnt[1] - p0, 0);
    d0 = din_cnt[0];
    p0 = pd_cnt[0];
    tx_q  = '{8'h91, 8'h92, 8'h93};
    exp_q = '{8'h91, 8'h92, 8'h93};
    send(1'b1);
    wait_out(3, 200, "t5_count");
    check_seq("t5_data");
    chk("t5_to_buf_a", din_cnt[0] - d0, 3);
    chk("t5_seal_a", pd_cnt[0] - p0, 1);
    repeat (6) tick();

    // T6: drain start timeout on buffer B
    out_q.delete();
    mute[1] = 1'b1;
    c1 = pck_cnt[1];
    tx_q = '{8'he1, 8'he2};
    send(1'b0);
    chk("t6_tmo_early", err_tmo, 1'b0);
    k = 0;
    while (!err_tmo && k < 100) begin tick(); k++; end
    chk("t6_tmo", err_tmo, 1'b1);
    repeat (4) tick();
    chk("t6_strobes", pck_cnt[1] - c1, 8);
    chk("t6_no_out", out_q.size(), 0);
    chk("t6_pop_en_low", buf_pop_en, 2'b00);

    // T7: reset mid-drain
    mute[1] = 1'b0;
    out_q.delete();
    tx_q = '{8'hb0, 8'hb1, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hbb};
    send(1'b0);
    k = 0;
    while (out_q.size() < 4 && k < 100) begin tick(); k++; end
    reset = 1'b1;
    tick();
    chk("t7_rst_usb", {usb_wr, buf_pop_en, buf_pop_ck_en}, 5'b00000);
    chk("t7_rst_flags", {ro_busy, err_ovf, err_tmo}, 3'b000);
    tick();
    reset = 1'b0;
    tick();
    out_q.delete();
    d0 = din_cnt[0];
    tx_q  = '{8'hc1, 8'hc2, 8'hc3};
    exp_q = '{8'hc1, 8'hc2, 8'hc3};
    send(1'b0);
    wait_out(3, 200, "t7_count");
    repeat (8) tick();
    chk("t7_no_extra", out_q.size(), 3);
    check_seq("t7_data");
    chk("t7_to_buf_a", din_cnt[0] - d0, 3);

    // T8: buffer depth saturation
    out_q.delete();
    d0 = din_cnt[1];
    for (int i = 0; i < 513; i++) begin
      ro_din_en = 1'b1;
      ro_din_d  = 8'(i);
      tick();
      if (i == 511) chk("t8_ovf_at_512", err_ovf, 1'b0);
    end
    ro_din_en = 1'b0;
    chk("t8_ovf_at_513", err_ovf, 1'b1);
    ro_done = 1'b1; tick(); ro_done = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    wait_out(512, 2000, "t8_count");
    repeat (8) tick();
    chk("t8_din_cnt", din_cnt[1] - d0, 512);
    chk("t8_no_extra", out_q.size(), 512);
    check_seq("t8_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
